// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared control-flow types and the predictor update payload
//
// Contents:
//   cflow_mode_t   control-flow class of a resolved instruction (CFLOW_NONE = not a cflow op)
//   cflow_hint_t   call/return hint used by the return-address logic
//   bp_upd_t       one predictor update: pc, mode, hint, taken, target
//   sched_state_t  update scheduler state (ST_CLEAR sweeping, ST_RUN normal)
//   sat_inc16      16-bit saturating increment
package riscv_defines;

   typedef enum logic [1:0] {
      CFLOW_NONE   = 2'd0,
      CFLOW_BRANCH = 2'd1,
      CFLOW_JAL    = 2'd2,
      CFLOW_JALR   = 2'd3
   } cflow_mode_t;

   typedef enum logic [1:0] {
      HINT_NONE  = 2'd0,
      HINT_CALL  = 2'd1,
      HINT_RET   = 2'd2,
      HINT_CORET = 2'd3
   } cflow_hint_t;

   typedef struct packed {
      logic [31:0] pc;
      cflow_mode_t mode;
      cflow_hint_t hint;
      logic        taken;
      logic [31:0] target;
   } bp_upd_t;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } sched_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - synchronous FIFO of predictor updates (bp_upd_t)
//
// Parameters:
//   DEPTH      number of entries, power of two, >= 2
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset, empties the FIFO
//   clr        synchronous clear, empties the FIFO on the next edge (wins over push/pop)
//   push       write push_data; ignored when full unless pop is also high
//   push_data  entry to write
//   pop        retire the head entry; ignored when empty
//   head       current head entry (stale contents when empty)
//   empty      no entries held
//   full       DEPTH entries held
module bp_upd_fifo
   import riscv_defines::*;
#(
   parameter int DEPTH = 4
)(
   input  logic    clk,
   input  logic    rst,
   input  logic    clr,
   input  logic    push,
   input  bp_upd_t push_data,
   input  logic    pop,
   output bp_upd_t head,
   output logic    empty,
   output logic    full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;
   bp_upd_t     mem_q [DEPTH];

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   // A push into a full FIFO is fine when the head leaves in the same cycle:
   // the freed slot is exactly the one being written.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; the empty flag masks stale entries.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - branch predictor table update scheduler with clear sweep
//
// Optional feature: BP_UPD_BYPASS_EN - when defined, an update arriving in RUN
// with the FIFO empty drives the table write combinationally in the same cycle
// and is only queued if the table does not grant it.
//
// Parameters:
//   DEPTH       update FIFO depth (power of two, >= 2)
//   IDX_W       predictor table index width (2^IDX_W entries)
// Ports:
//   clk         clock
//   start       asynchronous active-high reset
//   flush_req   pulse: empty the FIFO and restart the clear sweep
//   upd_*       resolved control-flow update from execute
//   tbl_we      table write valid
//   tbl_clr     write is an invalidate (clear sweep)
//   tbl_idx     table index of the write
//   tbl_pc, tbl_mode, tbl_hint, tbl_taken, tbl_target   write payload
//   tbl_gnt     table accepts the write this cycle
//   pred_en     predictions usable (tables fully cleared)
//   drop_cnt    saturating count of updates lost to FIFO overflow
module bp_update_sched
   import riscv_defines::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = 6
)(
   input  logic             clk,
   input  logic             start,
   input  logic             flush_req,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  cflow_mode_t      upd_mode,
   input  cflow_hint_t      upd_hint,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   output logic             tbl_we,
   output logic             tbl_clr,
   output logic [IDX_W-1:0] tbl_idx,
   output logic [31:0]      tbl_pc,
   output cflow_mode_t      tbl_mode,
   output cflow_hint_t      tbl_hint,
   output logic             tbl_taken,
   output logic [31:0]      tbl_target,
   input  logic             tbl_gnt,
   output logic             pred_en,
   output logic [15:0]      drop_cnt
);

   localparam logic [IDX_W-1:0] LAST_IDX = '1;
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   sched_state_t     state_q, state_d;
   logic [IDX_W-1:0] sweep_q, sweep_d;
   logic [15:0]      drop_q, drop_d;
   // Low while start is held and until the first edge after release, so the
   // outputs are quiet during reset and the sweep starts on that edge.
   logic             active_q, active_d;

   logic    enq_req;
   logic    fifo_push, fifo_pop, fifo_empty, fifo_full;
   bp_upd_t upd_in, fifo_head, wr_upd;

   assign upd_in = '{pc: upd_pc, mode: upd_mode, hint: upd_hint,
                     taken: upd_taken, target: upd_target};

   // Flush wins over a same-cycle update, which is discarded uncounted.
   assign enq_req = upd_valid && (upd_mode != CFLOW_NONE) && (state_q == ST_RUN) && !flush_req;

   assign pred_en  = (state_q == ST_RUN);
   assign drop_cnt = drop_q;

   bp_upd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (start),
      .clr       (flush_req),
      .push      (fifo_push),
      .push_data (upd_in),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      drop_d    = drop_q;
      active_d  = 1'b1;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
      wr_upd    = '0;
      tbl_we    = 1'b0;
      tbl_clr   = 1'b0;
      tbl_idx   = '0;

      case (state_q)
         ST_CLEAR: begin
            if (active_q) begin
               tbl_we  = 1'b1;
               tbl_clr = 1'b1;
               tbl_idx = sweep_q;
               if (tbl_gnt) begin
                  if (sweep_q == LAST_IDX) begin
                     state_d = ST_RUN;
                     sweep_d = '0;
                  end else begin
                     sweep_d = sweep_q + IDX_ONE;
                  end
               end
            end
         end
         ST_RUN: begin
            fifo_push = enq_req;
            if (!fifo_empty) begin
               tbl_we   = 1'b1;
               wr_upd   = fifo_head;
               fifo_pop = tbl_gnt;
            end
`ifdef BP_UPD_BYPASS_EN
            else if (enq_req) begin
               tbl_we    = 1'b1;
               wr_upd    = upd_in;
               fifo_push = !tbl_gnt;
            end
`endif
            if (enq_req && fifo_full && !fifo_pop) begin
               fifo_push = 1'b0;
               drop_d    = sat_inc16(drop_q);
            end
            if (tbl_we) tbl_idx = wr_upd.pc[IDX_W+1:2];
         end
         default: state_d = ST_CLEAR;
      endcase

      if (flush_req) begin
         state_d = ST_CLEAR;
         sweep_d = '0;
      end
   end

   assign tbl_pc     = wr_upd.pc;
   assign tbl_mode   = wr_upd.mode;
   assign tbl_hint   = wr_upd.hint;
   assign tbl_taken  = wr_upd.taken;
   assign tbl_target = wr_upd.target;

   always_ff @(posedge clk or posedge start) begin
      if (start) begin
         state_q  <= ST_CLEAR;
         sweep_q  <= '0;
         drop_q   <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sweep_q  <= sweep_d;
         drop_q   <= drop_d;
         active_q <= active_d;
      end
   end

endmodule

// File: tb/tb_bp_update_sched.sv
// tb/tb_bp_update_sched.sv - self-checking bench for bp_update_sched
module tb_bp_update_sched;
   import riscv_defines::*;

   localparam int DEPTH = 4;
   localparam int IDX_W = 6;
   localparam int N_IDX = 64;
`ifdef BP_UPD_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             start = 1'b1;
   logic             flush_req = 1'b0;
   logic             upd_valid = 1'b0;
   logic [31:0]      upd_pc = '0;
   cflow_mode_t      upd_mode = CFLOW_NONE;
   cflow_hint_t      upd_hint = HINT_NONE;
   logic             upd_taken = 1'b0;
   logic [31:0]      upd_target = '0;
   logic             tbl_gnt = 1'b0;
   logic             tbl_we, tbl_clr, tbl_taken, pred_en;
   logic [IDX_W-1:0] tbl_idx;
   logic [31:0]      tbl_pc, tbl_target;
   cflow_mode_t      tbl_mode;
   cflow_hint_t      tbl_hint;
   logic [15:0]      drop_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bp_update_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk(clk), .start(start), .flush_req(flush_req),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_mode(upd_mode), .upd_hint(upd_hint),
      .upd_taken(upd_taken), .upd_target(upd_target),
      .tbl_we(tbl_we), .tbl_clr(tbl_clr), .tbl_idx(tbl_idx), .tbl_pc(tbl_pc),
      .tbl_mode(tbl_mode), .tbl_hint(tbl_hint), .tbl_taken(tbl_taken), .tbl_target(tbl_target),
      .tbl_gnt(tbl_gnt), .pred_en(pred_en), .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic             valid;
      logic [31:0]      pc;
      cflow_mode_t      mode;
      cflow_hint_t      hint;
      logic             taken;
      logic [31:0]      target;
      logic             exp_wr;
      logic [IDX_W-1:0] exp_idx;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      upd_valid = 1'b0;
      upd_mode  = CFLOW_NONE;
      upd_hint  = HINT_NONE;
      upd_pc    = '0;
      upd_taken = 1'b0;
      upd_target = '0;
      flush_req = 1'b0;
   endtask

   task automatic drive_upd(input logic v, input logic [31:0] pc, input cflow_mode_t m,
                            input cflow_hint_t h, input logic t, input logic [31:0] tg);
      upd_valid = v; upd_pc = pc; upd_mode = m; upd_hint = h; upd_taken = t; upd_target = tg;
   endtask

   function automatic logic [95:0] obs();
      return 96'({tbl_we, tbl_clr, tbl_idx, tbl_pc, tbl_mode, tbl_hint, tbl_taken, tbl_target});
   endfunction

   function automatic logic [95:0] exp_wr(input logic we, input logic [IDX_W-1:0] idx,
                                          input logic [31:0] pc, input cflow_mode_t m,
                                          input cflow_hint_t h, input logic t, input logic [31:0] tg);
      if (!we) return '0;
      return 96'({1'b1, 1'b0, idx, pc, m, h, t, tg});
   endfunction

   // Table index of a PC: word address modulo the table size.
   function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc);
      return IDX_W'((pc / 32'd4) % N_IDX);
   endfunction

   // Expects the clear sweep to be at index 0 with tbl_gnt held high.
   task automatic check_sweep(input string tag);
      for (int i = 0; i < N_IDX; i++) begin
         #1;
         chk({tag, "_we_clr_pred"}, 96'({tbl_we, tbl_clr, pred_en}), 96'(3'b110));
         chk({tag, "_idx"}, 96'(tbl_idx), 96'(i));
         tick();
      end
      #1;
      chk({tag, "_run"}, 96'({pred_en, tbl_we, tbl_clr}), 96'(3'b100));
   endtask

   bp_upd_t q [$];
   bp_upd_t cur;
   int      drop_m;

   initial begin
      vecs[0] = '{1'b1, 32'h0000_0104, CFLOW_BRANCH, HINT_NONE,  1'b1, 32'h0000_0200, 1'b1, 6'h01};
      vecs[1] = '{1'b1, 32'h1234_5678, CFLOW_JAL,    HINT_CALL,  1'b1, 32'h1000_0000, 1'b1, 6'h1E};
      vecs[2] = '{1'b1, 32'hFFFF_FFFF, CFLOW_JALR,   HINT_RET,   1'b1, 32'hDEAD_BEEC, 1'b1, 6'h3F};
      vecs[3] = '{1'b1, 32'h0000_0104, CFLOW_NONE,   HINT_NONE,  1'b1, 32'h0000_0300, 1'b0, 6'h00};
      vecs[4] = '{1'b0, 32'h0000_0208, CFLOW_BRANCH, HINT_NONE,  1'b1, 32'h0000_0400, 1'b0, 6'h00};
      vecs[5] = '{1'b1, 32'h0000_0100, CFLOW_BRANCH, HINT_NONE,  1'b0, 32'h0000_0500, 1'b1, 6'h00};
      vecs[6] = '{1'b1, 32'h8000_0040, CFLOW_JAL,    HINT_CORET, 1'b1, 32'h8000_1000, 1'b1, 6'h10};
      vecs[7] = '{1'b1, 32'h0000_00FC, CFLOW_BRANCH, HINT_NONE,  1'b1, 32'h0000_0010, 1'b1, 6'h3F};

      // Reset state
      tick();
      tick();
      chk("reset_outputs", obs(), 96'(0));
      chk("reset_pred_drop", 96'({pred_en, drop_cnt}), 96'(0));

      // Release with grant: 64-entry sweep then RUN
      start = 1'b0;
      tbl_gnt = 1'b1;
      tick();
      check_sweep("sweep0");

      // Single updates, FIFO empty, grant high
      for (int v = 0; v < 8; v++) begin
         drive_upd(vecs[v].valid, vecs[v].pc, vecs[v].mode, vecs[v].hint, vecs[v].taken, vecs[v].target);
         #1;
         chk($sformatf("vec%0d_c0", v), obs(),
             exp_wr(BYPASS && vecs[v].exp_wr, vecs[v].exp_idx, vecs[v].pc, vecs[v].mode,
                    vecs[v].hint, vecs[v].taken, vecs[v].target));
         tick();
         set_idle();
         #1;
         chk($sformatf("vec%0d_c1", v), obs(),
             exp_wr(!BYPASS && vecs[v].exp_wr, vecs[v].exp_idx, vecs[v].pc, vecs[v].mode,
                    vecs[v].hint, vecs[v].taken, vecs[v].target));
         tick();
      end
      chk("vec_drop", 96'(drop_cnt), 96'(0));

      // Overflow: 6 pushes into a 4-deep FIFO with no grant
      tbl_gnt = 1'b0;
      for (int k = 0; k < 6; k++) begin
         drive_upd(1'b1, 32'h0000_1000 + 32'(k * 8), CFLOW_BRANCH, HINT_NONE, 1'b1, 32'(k + 100));
         tick();
      end
      set_idle();
      #1;
      chk("ovf_drop", 96'(drop_cnt), 96'(2));
      chk("ovf_hold", obs(), exp_wr(1'b1, 6'h00, 32'h0000_1000, CFLOW_BRANCH, HINT_NONE, 1'b1, 32'd100));
      tick();
      #1;
      chk("ovf_hold2", obs(), exp_wr(1'b1, 6'h00, 32'h0000_1000, CFLOW_BRANCH, HINT_NONE, 1'b1, 32'd100));
      tbl_gnt = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("ovf_drain%0d", k), obs(),
             exp_wr(1'b1, IDX_W'(2 * k), 32'h0000_1000 + 32'(k * 8), CFLOW_BRANCH, HINT_NONE, 1'b1, 32'(k + 100)));
         tick();
      end
      #1;
      chk("ovf_empty", obs(), 96'(0));

      // Reset with three queued entries
      tbl_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_upd(1'b1, 32'h0000_2000 + 32'(k * 4), CFLOW_JAL, HINT_CALL, 1'b1, 32'h0000_3000);
         tick();
      end
      set_idle();
      #1;
      chk("rst3_before", 96'({tbl_we, drop_cnt}), 96'({1'b1, 16'd2}));
      start = 1'b1;
      #1;
      chk("rst3_outputs", obs(), 96'(0));
      chk("rst3_pred_drop", 96'({pred_en, drop_cnt}), 96'(0));
      tick();
      start = 1'b0;
      tbl_gnt = 1'b1;
      tick();

      // Flush at sweep index 20 restarts the sweep
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("pre_flush_idx", 96'(tbl_idx), 96'(i));
         tick();
      end
      #1;
      chk("flush_at_idx", 96'({tbl_clr, tbl_idx}), 96'({1'b1, 6'd20}));
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      check_sweep("resweep");

      // Flush in RUN together with an update: FIFO emptied, update not counted
      tbl_gnt = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive_upd(1'b1, 32'h0000_4000 + 32'(k * 4), CFLOW_BRANCH, HINT_NONE, 1'b0, 32'h0000_5000);
         tick();
      end
      set_idle();
      #1;
      chk("runflush_pre", 96'(tbl_we), 96'(1));
      drive_upd(1'b1, 32'h0000_6000, CFLOW_BRANCH, HINT_NONE, 1'b1, 32'h0000_7000);
      flush_req = 1'b1;
      tick();
      set_idle();
      #1;
      chk("runflush_clear", 96'({pred_en, tbl_we, tbl_clr, tbl_idx}), 96'({3'b011, 6'd0}));
      tick();
      tick();
      #1;
      chk("clear_hold_no_gnt", 96'({tbl_clr, tbl_idx}), 96'({1'b1, 6'd0}));
      tbl_gnt = 1'b1;
      check_sweep("sweep_after_flush");
      chk("runflush_empty", obs(), 96'(0));
      chk("runflush_drop", 96'(drop_cnt), 96'(0));

      // Randomized traffic against a queue model
      q.delete();
      drop_m = 0;
      for (int c = 0; c < 600; c++) begin
         logic [1:0]  m2;
         logic [1:0]  h2;
         logic        acc, wr, byp, gnt;
         logic [95:0] e;
         m2 = 2'($urandom_range(0, 3));
         h2 = 2'($urandom_range(0, 3));
         gnt = ($urandom_range(0, 2) == 0);
         drive_upd(($urandom_range(0, 3) != 0), $urandom, cflow_mode_t'(m2), cflow_hint_t'(h2),
                   1'($urandom_range(0, 1)), $urandom);
         tbl_gnt = gnt;
         #1;
         cur = '{pc: upd_pc, mode: upd_mode, hint: upd_hint, taken: upd_taken, target: upd_target};
         acc = upd_valid && (upd_mode != CFLOW_NONE);
         wr = 1'b0;
         byp = 1'b0;
         e = '0;
         if (q.size() > 0) begin
            wr = 1'b1;
            e = exp_wr(1'b1, idx_of(q[0].pc), q[0].pc, q[0].mode, q[0].hint, q[0].taken, q[0].target);
         end else if (BYPASS && acc) begin
            wr = 1'b1;
            byp = 1'b1;
            e = exp_wr(1'b1, idx_of(cur.pc), cur.pc, cur.mode, cur.hint, cur.taken, cur.target);
         end
         chk("rnd_write", obs(), e);
         chk("rnd_drop", 96'(drop_cnt), 96'(drop_m));
         if (wr && gnt && !byp) void'(q.pop_front());
         if (acc) begin
            if (byp) begin
               if (!gnt) q.push_back(cur);
            end else if (q.size() < DEPTH) begin
               q.push_back(cur);
            end else if (drop_m < 65535) begin
               drop_m++;
            end
         end
         tick();
      end
      set_idle();
      #1;
      chk("rnd_final_drop", 96'(drop_cnt), 96'(drop_m));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bp_update_sched.md
BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the update FIFO depth (power of two, at least 2).
REQ-002 The block SHALL have parameter IDX_W, default 6, giving the predictor table index width (2^IDX_W entries).
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have the port start, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have the port flush_req, input, 1 bit: one-cycle pulse that requests a full clear of the predictor tables.
REQ-006 The block SHALL have the port upd_valid, input, 1 bit: a resolved control-flow update is present from execute.
REQ-007 The block SHALL have the port upd_pc, input, 32 bits: PC of the resolved instruction.
REQ-008 The block SHALL have the port upd_mode, input, cflow_mode_t: control-flow mode of the resolved instruction.
REQ-009 The block SHALL have the port upd_hint, input, cflow_hint_t: call/return hint of the resolved instruction.
REQ-010 The block SHALL have the port upd_taken, input, 1 bit: resolved direction.
REQ-011 The block SHALL have the port upd_target, input, 32 bits: resolved target address.
REQ-012 The block SHALL have the port tbl_we, output, 1 bit: a table write request is valid.
REQ-013 The block SHALL have the port tbl_clr, output, 1 bit: the current write is a clear (invalidate) write.
REQ-014 The block SHALL have the port tbl_idx, output, IDX_W bits: index of the table write.
REQ-015 The block SHALL have the port tbl_pc, output, 32 bits: PC of the update being written.
REQ-016 The block SHALL have the ports tbl_mode, tbl_hint, tbl_taken and tbl_target, outputs, carrying the payload of the update being written.
REQ-017 The block SHALL have the port tbl_gnt, input, 1 bit: the table accepts the write this cycle.
REQ-018 The block SHALL have the port pred_en, output, 1 bit: predictions are allowed to be used.
REQ-019 The block SHALL have the port drop_cnt, output, 16 bits: saturating count of updates lost to FIFO overflow.

Function
REQ-020 The state machine SHALL have two states: CLEAR and RUN.
REQ-021 In CLEAR: tbl_we=1, tbl_clr=1, and tbl_idx sweeps 0 to 2^IDX_W-1, advancing one step per cycle only while tbl_gnt=1.
REQ-022 The transition CLEAR->RUN SHALL occur on the cycle after the grant of the last index; pred_en SHALL be 0 in CLEAR and 1 in RUN.
REQ-023 An update SHALL be enqueued when upd_valid=1, upd_mode!=CFLOW_NONE and the state is RUN; updates in CLEAR SHALL be discarded and not counted.
REQ-024 The FIFO head SHALL be presented in RUN: tbl_we=1, tbl_clr=0, tbl_idx=upd_pc[IDX_W+1:2], with the payload taken from the head.
REQ-025 The head SHALL be popped only on tbl_we && tbl_gnt, and the outputs SHALL hold stable while tbl_gnt=0.
REQ-026 Latency (no bypass): an update enqueued in cycle N SHALL first appear on tbl_* in cycle N+1 if the FIFO was empty.
REQ-027 Full FIFO: a push with a same-cycle pop SHALL be accepted; a push without a pop SHALL be dropped and increment drop_cnt, saturating at 16'hFFFF.
REQ-028 tbl_we SHALL be 0 in RUN when the FIFO is empty, and all payload outputs SHALL then be 0.
REQ-029 flush_req in any state SHALL empty the FIFO, reset the sweep index to 0 and enter CLEAR next cycle; a flush mid-sweep restarts the sweep.
REQ-030 flush_req together with upd_valid SHALL cause the flush to win and the update to be discarded uncounted.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH, with one extra bit for the full/empty distinction.

Reset
REQ-032 start=1 SHALL asynchronously force state CLEAR, sweep index 0, FIFO empty and drop_cnt 0.
REQ-033 During reset the outputs SHALL be: tbl_we=0, tbl_clr=0, tbl_idx=0, payload 0, pred_en=0.
REQ-034 The sweep SHALL begin on the first clk edge after start deasserts.

Configuration
REQ-035 With BP_UPD_BYPASS_EN defined, in RUN with an empty FIFO, an accepted update SHALL drive tbl_* combinationally in the same cycle, and SHALL be enqueued only if tbl_gnt=0.
REQ-036 Without BP_UPD_BYPASS_EN, every update SHALL pass through the FIFO as in REQ-026.

Structure
REQ-037 cflow_mode_t (including CFLOW_NONE), cflow_hint_t and the bp_upd_t payload struct SHALL live in riscv_defines.
REQ-038 There SHALL be one sub-module, bp_upd_fifo (synchronous FIFO of bp_upd_t, DEPTH entries); the state machine and counter SHALL live in bp_update_sched.

Verification
REQ-039 Release start with tbl_gnt=1 -> tbl_clr=1 with idx 0..63 on 64 consecutive cycles, then pred_en=1 in the next cycle.
REQ-040 In RUN with an empty FIFO, tbl_gnt=1, upd_pc=0x0000_0104, BRANCH taken -> tbl_we=1, tbl_idx=6'h01 one cycle later (same cycle with BP_UPD_BYPASS_EN).
REQ-041 With tbl_gnt=0, push 6 updates with DEPTH=4 -> 4 held and drop_cnt=2; then raise tbl_gnt -> 4 writes in order.
REQ-042 Pulse flush_req at sweep index 20 -> the next cycle shows tbl_idx=0 and the full 64-entry sweep repeats.
REQ-043 Update with upd_mode=CFLOW_NONE -> no enqueue and tbl_we stays 0.
REQ-044 Assert start while the FIFO holds 3 entries -> outputs go to zero immediately and drop_cnt=0.
